// File: rtl/touch_pkg.sv
// Shared types and defaults for the touch sample averaging path.
// Imported by the averager top and its per-axis accumulator.
package touch_pkg;

    localparam int DATA_W_DEF = 9;
    localparam int LOG2_N_DEF = 3;
    localparam int PENUP_DEF  = 2;
    localparam logic [DATA_W_DEF-1:0] Z_THRESH_DEF = 9'd40;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/touch_axis_accum.sv
// Unsigned running sum for one axis of a sample block.
// Clear has priority over add so a block can be dropped in any cycle.
module touch_axis_accum
    import touch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = DATA_W_DEF + LOG2_N_DEF
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] value,
    output logic [SUM_W-1:0]  sum
);

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + SUM_W'(value);
        end
    end

endmodule

// File: rtl/touch_sample_averager.sv
// Pressure-gated box-car averager for touchpad x/y with debounced pen state.
// One averaged point is emitted per block of 2^LOG2_N accepted samples.
module touch_sample_averager
    import touch_pkg::*;
#(
    parameter int                DATA_W        = DATA_W_DEF,
    parameter int                LOG2_N        = LOG2_N_DEF,
    parameter logic [DATA_W-1:0] Z_THRESH      = Z_THRESH_DEF,
    parameter int                PENUP_SAMPLES = PENUP_DEF
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] z_in,
    output logic [DATA_W-1:0] x_avg,
    output logic [DATA_W-1:0] y_avg,
    output logic              avg_valid,
    output logic              touching
);

    localparam int SUM_W = DATA_W + LOG2_N;
    localparam int RJ_W  = $clog2(PENUP_SAMPLES + 1);
    localparam logic [RJ_W-1:0] RJ_MAX = RJ_W'(PENUP_SAMPLES);

    state_t            state_q;
    state_t            state_d;
    logic [LOG2_N-1:0] count_q;
    logic [RJ_W-1:0]   rej_q;
    logic [RJ_W-1:0]   rej_d;
    logic [SUM_W-1:0]  sum_x;
    logic [SUM_W-1:0]  sum_y;
    logic [SUM_W-1:0]  tot_x;
    logic [SUM_W-1:0]  tot_y;
    logic              accept;
    logic              reject;
    logic              last;
    logic              acc_add;
    logic              acc_clr;
    logic              blk_done;

    assign accept = sample_valid && (z_in >= Z_THRESH);
    assign reject = sample_valid && (z_in < Z_THRESH);
    // N is a power of two, so the final slot is the all-ones count
    assign last   = &count_q;
    assign tot_x  = sum_x + SUM_W'(x_in);
    assign tot_y  = sum_y + SUM_W'(y_in);

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ACCUM;
            end
            ACCUM: begin
                if (reject || (accept && last)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_add  = 1'b0;
        acc_clr  = 1'b0;
        blk_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                acc_add = accept;
            end
            ACCUM: begin
                unique case (1'b1)
                    accept && last: begin
                        acc_clr  = 1'b1;
                        blk_done = 1'b1;
                    end
                    accept && !last: acc_add = 1'b1;
                    reject:          acc_clr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // A reject mid-block always restarts the pen-up run at one
    always_comb begin
        rej_d = rej_q;
        if (accept) begin
            rej_d = '0;
        end else if (reject) begin
            if (state_q == ACCUM) begin
                rej_d = RJ_W'(1);
            end else if (rej_q != RJ_MAX) begin
                rej_d = rej_q + RJ_W'(1);
            end
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            count_q   <= '0;
            rej_q     <= '0;
            touching  <= 1'b0;
            avg_valid <= 1'b0;
            x_avg     <= '0;
            y_avg     <= '0;
        end else begin
            rej_q     <= rej_d;
            avg_valid <= blk_done;
            if (acc_clr) begin
                count_q <= '0;
            end else if (acc_add) begin
                count_q <= count_q + LOG2_N'(1);
            end
            if (blk_done) begin
                x_avg    <= DATA_W'(tot_x >> LOG2_N);
                y_avg    <= DATA_W'(tot_y >> LOG2_N);
                touching <= 1'b1;
            end else if (reject && (rej_d == RJ_MAX)) begin
                touching <= 1'b0;
            end
        end
    end

    touch_axis_accum #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_acc_x (
        .cclk  (cclk),
        .rstb  (rstb),
        .clear (acc_clr),
        .add   (acc_add),
        .value (x_in),
        .sum   (sum_x)
    );

    touch_axis_accum #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_acc_y (
        .cclk  (cclk),
        .rstb  (rstb),
        .clear (acc_clr),
        .add   (acc_add),
        .value (y_in),
        .sum   (sum_y)
    );

endmodule

// File: tb/tb_touch_sample_averager.sv
// Directed and randomized bench for touch_sample_averager.
// Reference model keeps the current block as queues and averages with plain arithmetic.
module tb_touch_sample_averager;

    logic       cclk = 1'b0;
    logic       rstb;
    logic       sample_valid;
    logic [8:0] x_in;
    logic [8:0] y_in;
    logic [8:0] z_in;
    logic [8:0] x_avg;
    logic [8:0] y_avg;
    logic       avg_valid;
    logic       touching;

    int checks = 0;
    int errors = 0;

    int blk_x[$];
    int blk_y[$];
    int rej_run = 0;
    int m_x = 0;
    int m_y = 0;
    int m_valid = 0;
    int m_touch = 0;

    touch_sample_averager dut (
        .cclk         (cclk),
        .rstb         (rstb),
        .sample_valid (sample_valid),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .x_avg        (x_avg),
        .y_avg        (y_avg),
        .avg_valid    (avg_valid),
        .touching     (touching)
    );

    always #5 cclk = ~cclk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".avg_valid"}, int'(avg_valid), m_valid);
        check({tag, ".x_avg"}, int'(x_avg), m_x);
        check({tag, ".y_avg"}, int'(y_avg), m_y);
        check({tag, ".touching"}, int'(touching), m_touch);
    endtask

    task automatic model_step(input int x, input int y, input int z);
        int sx, sy;
        m_valid = 0;
        if (z >= 40) begin
            blk_x.push_back(x);
            blk_y.push_back(y);
            rej_run = 0;
            if (blk_x.size() == 8) begin
                sx = 0;
                sy = 0;
                foreach (blk_x[i]) sx += blk_x[i];
                foreach (blk_y[i]) sy += blk_y[i];
                m_x = sx / 8;
                m_y = sy / 8;
                m_valid = 1;
                m_touch = 1;
                blk_x.delete();
                blk_y.delete();
            end
        end else begin
            blk_x.delete();
            blk_y.delete();
            if (rej_run < 2) rej_run++;
            if (rej_run == 2) m_touch = 0;
        end
    endtask

    task automatic send(input string tag, input int x, input int y, input int z);
        @(negedge cclk);
        x_in = 9'(x);
        y_in = 9'(y);
        z_in = 9'(z);
        sample_valid = 1'b1;
        @(posedge cclk);
        #1;
        sample_valid = 1'b0;
        x_in = 9'($urandom_range(0, 511));
        y_in = 9'($urandom_range(0, 511));
        z_in = 9'($urandom_range(0, 511));
        model_step(x, y, z);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) begin
            @(posedge cclk);
            #1;
            m_valid = 0;
            check_all(tag);
        end
    endtask

    task automatic do_reset(input string tag);
        rstb = 1'b0;
        #1;
        blk_x.delete();
        blk_y.delete();
        rej_run = 0;
        m_x = 0;
        m_y = 0;
        m_valid = 0;
        m_touch = 0;
        check_all(tag);
        @(negedge cclk);
        rstb = 1'b1;
    endtask

    initial begin
        int xs, ys, zs, gap;
        rstb = 1'b0;
        sample_valid = 1'b0;
        x_in = '0;
        y_in = '0;
        z_in = '0;
        repeat (3) @(posedge cclk);
        #1;
        do_reset("reset");
        idle("post_reset", 2);

        for (int i = 0; i < 8; i++) send("t1", 100, 200, 80);
        idle("t1_hold", 3);

        for (int i = 0; i < 8; i++) send("t2", i, 511, 40);
        idle("t2_hold", 1);

        for (int i = 0; i < 5; i++) send("t3a", 77, 300, 90);
        send("t3_rej", 400, 400, 39);
        for (int i = 0; i < 8; i++) send("t3b", 50, 60, 120);
        idle("t3_hold", 2);

        send("t4_rej1", 1, 2, 10);
        idle("t4_gap", 2);
        send("t4_rej2", 3, 4, 0);
        idle("t4_hold", 2);

        for (int i = 0; i < 8; i++) send("t5_fill", 300 + i, 10 * i, 200);
        for (int i = 0; i < 3; i++) begin
            send("t5_rej", 5, 5, 20);
            idle("t5_gap", 1);
            send("t5_acc", 6, 6, 60);
        end
        send("t5_rej_end", 5, 5, 20);

        for (int i = 0; i < 4; i++) send("t6_part", 400, 400, 100);
        do_reset("t6_reset");
        for (int i = 0; i < 8; i++) send("t6", 20, 30, 100);
        idle("t6_hold", 1);

        for (int n = 0; n < 300; n++) begin
            xs = $urandom_range(0, 511);
            ys = $urandom_range(0, 511);
            if ($urandom_range(0, 19) == 0) zs = $urandom_range(0, 39);
            else zs = $urandom_range(40, 511);
            send("rand", xs, ys, zs);
            gap = $urandom_range(0, 39);
            if (gap > 0) idle("rand_gap", gap);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
